// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end.
//   - fetch FSM state encoding (as localparams and as an enum built from them)
//   - PC increment and default reset vector
package cpu_pkg;

  localparam int          PC_INC        = 4;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_FETCH      = 2'd1;
  localparam logic [1:0] ST_REDIR_WAIT = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE       = ST_IDLE,
    S_FETCH      = ST_FETCH,
    S_REDIR_WAIT = ST_REDIR_WAIT
  } fetch_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance statistics.
//   clk    : clock
//   rst_n  : synchronous active-low clear
//   inc    : count this cycle
//   count  : current value, holds at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Next-PC selection and fetch sequencing for the IF stage.
// Drives the PC register (pc_result/stall_ctrl) and the IF/ID register
// (if_id_stall/if_id_flush), arbitrating sequential fetch, EX branch
// redirects, ID jump redirects, load-use stalls and imem wait states.
//
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   pc_addr          : current PC from the PC register
//   imem_ready       : imem returns data for pc_addr this cycle
//   load_use_hazard  : ID-stage load-use hazard (held by its source)
//   br_taken/br_target   : EX branch redirect (wins over jump: older insn)
//   jmp_valid/jmp_target : ID jump redirect
//   imem_req         : fetch request for pc_addr
//   pc_result        : next PC, always word aligned
//   stall_ctrl       : hold the PC register
//   if_id_stall      : hold IF/ID
//   if_id_flush      : load a bubble into IF/ID (never together with stall)
//   stall_cnt        : saturating count of stall_ctrl cycles outside IDLE
//   state_dbg        : current FSM state
//
// Handshake: imem_req is held high for pc_addr in every non-IDLE cycle;
// a fetch completes in the cycle imem_ready=1 and nothing is buffered, so
// a cycle with imem_req=1 and imem_ready=0 simply repeats the request.
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int                 WIDTH_I   = 32,
  parameter logic [WIDTH_I-1:0] RESET_VEC = WIDTH_I'(RESET_VEC_DEF),
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH_I-1:0] pc_addr,
  input  logic               imem_ready,
  input  logic               load_use_hazard,
  input  logic               br_taken,
  input  logic [WIDTH_I-1:0] br_target,
  input  logic               jmp_valid,
  input  logic [WIDTH_I-1:0] jmp_target,
  output logic               imem_req,
  output logic [WIDTH_I-1:0] pc_result,
  output logic               stall_ctrl,
  output logic               if_id_stall,
  output logic               if_id_flush,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [1:0]         state_dbg
);

  localparam logic [WIDTH_I-1:0] ALIGN_MASK = ~WIDTH_I'(3);

  fetch_state_e       state, state_nxt;
  logic [WIDTH_I-1:0] pend_target, pend_nxt;
  logic               redirect;
  logic [WIDTH_I-1:0] target;
  logic [WIDTH_I-1:0] seq_pc;

  assign redirect  = br_taken | jmp_valid;
  assign target    = (br_taken ? br_target : jmp_target) & ALIGN_MASK;
  assign seq_pc    = (pc_addr + WIDTH_I'(PC_INC)) & ALIGN_MASK;
  assign state_dbg = state;

  // Defaults describe the common "hold PC, bubble IF/ID" case; each branch
  // only overrides what differs from it.
  always_comb begin
    state_nxt   = state;
    pend_nxt    = pend_target;
    imem_req    = 1'b1;
    pc_result   = pc_addr & ALIGN_MASK;
    stall_ctrl  = 1'b1;
    if_id_stall = 1'b0;
    if_id_flush = 1'b1;
    unique case (state)
      S_IDLE: begin
        imem_req  = 1'b0;
        pc_result = RESET_VEC & ALIGN_MASK;
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready) begin
          if (redirect) begin
            pc_result  = target;
            stall_ctrl = 1'b0;
          end else if (load_use_hazard) begin
            if_id_stall = 1'b1;
            if_id_flush = 1'b0;
          end else begin
            pc_result   = seq_pc;
            stall_ctrl  = 1'b0;
            if_id_flush = 1'b0;
          end
        end else if (redirect) begin
          // The outstanding fetch belongs to the wrong path; remember where
          // to go once imem finishes it.
          pend_nxt  = target;
          state_nxt = S_REDIR_WAIT;
        end else if (load_use_hazard) begin
          if_id_stall = 1'b1;
          if_id_flush = 1'b0;
        end
      end
      S_REDIR_WAIT: begin
        // Flush supersedes load-use here, so the hazard input is unused.
        if (imem_ready) begin
          pc_result  = redirect ? target : pend_target;
          stall_ctrl = 1'b0;
          state_nxt  = S_FETCH;
        end else if (redirect) begin
          pend_nxt = target;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pend_target <= '0;
    end else begin
      state       <= state_nxt;
      pend_target <= pend_nxt;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_ctrl && (state != S_IDLE)),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  localparam int          W   = 32;
  localparam int          CW  = 4;
  localparam logic [W-1:0] RV = '0;
  localparam int          CNT_MAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] pc_addr;
  logic         imem_ready, load_use_hazard, br_taken, jmp_valid;
  logic [W-1:0] br_target, jmp_target;
  logic         imem_req, stall_ctrl, if_id_stall, if_id_flush;
  logic [W-1:0] pc_result;
  logic [CW-1:0] stall_cnt;
  logic [1:0]   state_dbg;

  fetch_ctrl #(.WIDTH_I(W), .RESET_VEC(RV), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .pc_addr(pc_addr), .imem_ready(imem_ready),
    .load_use_hazard(load_use_hazard), .br_taken(br_taken), .br_target(br_target),
    .jmp_valid(jmp_valid), .jmp_target(jmp_target), .imem_req(imem_req),
    .pc_result(pc_result), .stall_ctrl(stall_ctrl), .if_id_stall(if_id_stall),
    .if_id_flush(if_id_flush), .stall_cnt(stall_cnt), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // "Phase" view of the controller: just out of reset, waiting on a
  // wrong-path fetch with a remembered target, or running.
  bit           m_valid = 0;
  bit           m_booting = 1;
  bit           m_pending = 0;
  logic [W-1:0] m_tgt = '0;
  int           m_cnt = 0;

  logic         e_req, e_stall, e_ifs, e_flush, e_pc_chk, e_redir;
  logic [W-1:0] e_pc, e_tgt;

  task automatic model_eval();
    e_redir  = br_taken | jmp_valid;
    e_tgt    = (br_taken ? br_target : jmp_target) & ~32'h3;
    e_req    = 1'b1;
    e_stall  = 1'b1;
    e_ifs    = 1'b0;
    e_flush  = 1'b1;
    e_pc_chk = 1'b0;
    e_pc     = '0;
    if (m_booting) begin
      e_req = 1'b0; e_pc_chk = 1'b1; e_pc = RV;
    end else if (m_pending) begin
      if (imem_ready) begin
        e_stall = 1'b0; e_pc_chk = 1'b1; e_pc = e_redir ? e_tgt : m_tgt;
      end
    end else if (imem_ready && e_redir) begin
      e_stall = 1'b0; e_pc_chk = 1'b1; e_pc = e_tgt;
    end else if (load_use_hazard && !e_redir) begin
      e_ifs = 1'b1; e_flush = 1'b0;
    end else if (imem_ready) begin
      e_stall = 1'b0; e_flush = 1'b0; e_pc_chk = 1'b1; e_pc = (pc_addr + 32'd4) & ~32'h3;
    end
  endtask

  // ---------------- PC register stand-in ----------------
  bit           follow = 0;
  logic [W-1:0] pc_reg = '0;
  logic         s_stall;
  logic [W-1:0] s_pc;

  // Compare DUT against the model mid-cycle.
  task automatic settle();
    @(negedge clk);
    s_stall = stall_ctrl;
    s_pc    = pc_result;
    if (m_valid) begin
      model_eval();
      chk("imem_req",    W'(imem_req),    W'(e_req));
      chk("stall_ctrl",  W'(stall_ctrl),  W'(e_stall));
      chk("if_id_stall", W'(if_id_stall), W'(e_ifs));
      chk("if_id_flush", W'(if_id_flush), W'(e_flush));
      chk("stall_cnt",   W'(stall_cnt),   W'(m_cnt));
      chk("stall_flush_excl", W'(if_id_stall & if_id_flush), '0);
      if (e_pc_chk) begin
        exp_q.push_back(e_pc);
        chk("pc_result", pc_result, exp_q.pop_front());
      end
    end
  endtask

  // Clock edge: advance the model and the PC register stand-in.
  task automatic advance();
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1; m_booting = 1; m_pending = 0; m_tgt = '0; m_cnt = 0;
    end else if (m_valid) begin
      model_eval();
      if (e_stall && !m_booting && m_cnt < CNT_MAX) m_cnt++;
      if (m_booting) m_booting = 0;
      else if (m_pending) begin
        if (imem_ready) m_pending = 0;
        else if (e_redir) m_tgt = e_tgt;
      end else if (!imem_ready && e_redir) begin
        m_pending = 1; m_tgt = e_tgt;
      end
    end
    if (follow && !s_stall) pc_reg = s_pc;
    #1;
    if (follow) pc_addr = pc_reg;
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  task automatic quiet();
    load_use_hazard = 0; br_taken = 0; jmp_valid = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; cycle();
    rst_n = 1; cycle();   // IDLE cycle
  endtask

  // ---------------- stimulus ----------------
  initial begin
    pc_addr = '0; imem_ready = 0; br_target = '0; jmp_target = '0;
    quiet();

    // Reset held for 3 edges; state is unknown before the first one.
    advance();
    repeat (2) begin
      settle();
      chk("rst_pc", pc_result, 32'h0);
      chk("rst_stall", W'(stall_ctrl), 1);
      chk("rst_flush", W'(if_id_flush), 1);
      chk("rst_cnt", W'(stall_cnt), 0);
      advance();
    end

    // Start-up: one IDLE cycle, then sequential walk.
    rst_n = 1; imem_ready = 1; follow = 1; pc_reg = '0; pc_addr = '0;
    settle(); chk("idle_req", W'(imem_req), 0); advance();
    settle(); chk("walk4", pc_result, 32'h4); advance();
    settle(); chk("walk8", pc_result, 32'h8); advance();
    settle(); chk("walkC", pc_result, 32'hC); advance();

    // Branch beats jump in the same cycle.
    follow = 0; pc_addr = 32'h100;
    br_taken = 1; br_target = 32'h200; jmp_valid = 1; jmp_target = 32'h300;
    settle();
    chk("bj_pc", pc_result, 32'h200);
    chk("bj_flush", W'(if_id_flush), 1);
    chk("bj_stall", W'(stall_ctrl), 0);
    advance(); quiet();

    // Load-use for two cycles from a clean counter.
    do_reset();
    follow = 1; pc_reg = 32'h40; pc_addr = 32'h40; imem_ready = 1; load_use_hazard = 1;
    repeat (2) begin
      settle();
      chk("lu_stall", W'(stall_ctrl), 1);
      chk("lu_ifs", W'(if_id_stall), 1);
      advance();
    end
    load_use_hazard = 0;
    settle();
    chk("lu_pc", pc_result, 32'h44);
    chk("lu_cnt", W'(stall_cnt), 2);
    advance();

    // Redirects while imem waits; unaligned targets get their low bits dropped.
    follow = 0; pc_addr = 32'h1000; imem_ready = 0;
    for (int c = 1; c <= 5; c++) begin
      quiet();
      if (c == 1) begin jmp_valid = 1; jmp_target = 32'h502; end
      if (c == 3) begin br_taken = 1; br_target = 32'h603; end
      if (c == 5) imem_ready = 1;
      settle();
      chk("rw_flush", W'(if_id_flush), 1);
      if (c == 5) begin
        chk("rw_pc", pc_result, 32'h600);
        chk("rw_stall", W'(stall_ctrl), 0);
      end
      advance();
    end
    quiet();

    // PC wrap.
    pc_addr = 32'hFFFF_FFFC; imem_ready = 1;
    settle(); chk("wrap_pc", pc_result, 32'h0); advance();

    // Counter saturation.
    imem_ready = 0;
    repeat (20) begin
      load_use_hazard = ($urandom_range(0, 1) == 1);
      cycle();
    end
    load_use_hazard = 0;
    settle(); chk("sat_cnt", W'(stall_cnt), 32'hF); advance();

    // Reset while a redirect is pending: the pending target is dropped.
    pc_addr = 32'h1000; imem_ready = 0; jmp_valid = 1; jmp_target = 32'h800;
    cycle(); quiet();
    settle(); chk("mw_no800_a", W'(pc_result == 32'h800), 0); advance();
    rst_n = 0;
    settle(); chk("mw_no800_b", W'(pc_result == 32'h800), 0); advance();
    rst_n = 1; imem_ready = 1;
    settle(); chk("mw_idle_pc", pc_result, RV); chk("mw_idle_req", W'(imem_req), 0); advance();
    settle(); chk("mw_seq_pc", pc_result, 32'h1004); advance();

    // Random traffic against the model.
    follow = 1; pc_reg = $urandom & ~32'h3; pc_addr = pc_reg;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin pc_reg = $urandom; pc_addr = pc_reg; end
      rst_n           = ($urandom_range(0, 99) != 0);
      imem_ready      = ($urandom_range(0, 3) != 0);
      load_use_hazard = ($urandom_range(0, 4) == 0);
      br_taken        = ($urandom_range(0, 7) == 0);
      jmp_valid       = ($urandom_range(0, 5) == 0);
      br_target       = $urandom;
      jmp_target      = $urandom;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
